md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 207 ++++++++++++++++++++
 tb/tb_md_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : iterative multiply / divide unit with HI/LO registers.
//
// One operation takes a fixed 34 cycles. The start edge is E0. There are
// 32 shift-add or shift-subtract steps at E1..E32. A sign-fix cycle writes
// HI/LO at E33, and the unit returns to IDLE at E34.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      begin the operation in op_i (honoured only in IDLE)
//   op_i         00 multu, 01 mult, 10 divu, 11 div
//   op_a_i       multiplicand / dividend
//   op_b_i       multiplier / divisor
//   hi_wr_i      write wdata_i to HI (IDLE only, start has priority)
//   lo_wr_i      write wdata_i to LO (IDLE only, start has priority)
//   wdata_i      data for hi_wr_i / lo_wr_i
//   busy_o       high whenever the unit is not IDLE
//   done_o       one-cycle pulse: new HI/LO visible this cycle
//   div_zero_o   one-cycle pulse with done_o on a divide by zero
//   hi_o, lo_o   HI and LO registers
// ---------------------------------------------------------------------------
module md_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        hi_wr_i,
    input  logic        lo_wr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Magnitude of a value, treating it as signed only when sgn is set.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        abs32 = (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        neg32 = en ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        neg64 = en ? (64'd0 - v) : v;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;       // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] mag_q, mag_d;       // magnitude of multiplicand or divisor
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d; // negate product / quotient in FIX
    logic        neg_rem_q, neg_rem_d; // negate remainder in FIX (dividend sign)
    logic        b_zero_q, b_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic [32:0] add_s;
    logic [32:0] trial_s;
    logic [63:0] mul_step_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // One iteration of each datapath plus the sign-corrected results.
    always_comb begin
        add_s      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
        mul_step_s = {add_s, acc_q[31:1]};
        // Remainder is always below the divisor, so the shifted value fits in 33 bits.
        trial_s    = acc_q[63:31] - {1'b0, mag_q};
        if (trial_s[32]) begin
            div_step_s = {acc_q[62:0], 1'b0};
        end else begin
            div_step_s = {trial_s[31:0], acc_q[30:0], 1'b1};
        end
        prod_s = neg64(acc_q, neg_res_q);
        quot_s = neg32(acc_q[31:0], neg_res_q);
        rem_s  = neg32(acc_q[63:32], neg_rem_q);
    end

    // Next-state logic for the controller and all registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_CALC;
                    cnt_d     = 5'd0;
                    is_div_d  = op_i[1];
                    b_zero_d  = (op_b_i == 32'd0);
                    neg_res_d = op_i[0] & (op_a_i[31] ^ op_b_i[31]);
                    neg_rem_d = op_i[0] & op_a_i[31];
                    if (op_i[1]) begin
                        acc_d = {32'd0, abs32(op_a_i, op_i[0])};
                        mag_d = abs32(op_b_i, op_i[0]);
                    end else begin
                        acc_d = {32'd0, abs32(op_b_i, op_i[0])};
                        mag_d = abs32(op_a_i, op_i[0]);
                    end
                end else begin
                    // Register writes only when no operation is being launched.
                    hi_d = hi_wr_i ? wdata_i : hi_q;
                    lo_d = lo_wr_i ? wdata_i : lo_q;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_step_s : mul_step_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                dz_d    = is_div_q & b_zero_q;
                if (is_div_q) begin
                    if (b_zero_q) begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end
                end else begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            mag_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : self-checking bench for md_unit. Expected HI/LO values come
// from a plain-arithmetic reference model of multiply/divide semantics.
// ---------------------------------------------------------------------------
module tb_md_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        hi_wr_i;
    logic        lo_wr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int passes = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .hi_wr_i(hi_wr_i), .lo_wr_i(lo_wr_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: architectural result of one operation on model_hi/lo.
    task automatic model_apply(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic dz);
        logic [63:0] up;
        longint      sp, sa, sb, q, r;
        dz = 1'b0;
        case (op)
            2'd0: begin
                up = {32'd0, a} * {32'd0, b};
                model_hi = up[63:32];
                model_lo = up[31:0];
            end
            2'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                model_hi = sp[63:32];
                model_lo = sp[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                end else if (op == 2'd2) begin
                    model_lo = a / b;
                    model_hi = a % b;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end
            end
        endcase
    endtask

    // Launch one operation (caller positioned between edges) and observe it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_edge, input bit poke_start, input bit poke_wr,
                          output int busy_cycles, output int done_edge, output int done_count,
                          output logic dz, output logic [31:0] hi_seen,
                          output logic [31:0] lo_seen, output logic [31:0] hi_e1);
        int edge_n;
        op_i = op; op_a_i = a; op_b_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; hi_wr_i = 1'b0; lo_wr_i = 1'b0;
        op_a_i = $urandom; op_b_i = $urandom; op_i = 2'($urandom_range(3, 0));
        busy_cycles = 0; done_edge = -1; done_count = 0; dz = 1'b0;
        hi_seen = 32'd0; lo_seen = 32'd0; hi_e1 = 32'd0; edge_n = 0;
        forever begin
            if (busy_o) busy_cycles++;
            if (done_o) begin
                if (done_count == 0) begin
                    done_edge = edge_n; dz = div_zero_o; hi_seen = hi_o; lo_seen = lo_o;
                end
                done_count++;
            end
            if (edge_n == 1) hi_e1 = hi_o;
            if (!busy_o || edge_n > 60) break;
            start_i = poke_start && (edge_n == poke_edge);
            hi_wr_i = poke_wr && (edge_n == poke_edge);
            lo_wr_i = poke_wr && (edge_n == poke_edge);
            wdata_i = $urandom;
            @(posedge clk_i); #1;
            edge_n++;
        end
        start_i = 1'b0; hi_wr_i = 1'b0; lo_wr_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; start_i = 1'b0; op_i = 2'd0; op_a_i = 32'd0; op_b_i = 32'd0;
        hi_wr_i = 1'b0; lo_wr_i = 1'b0; wdata_i = 32'd0;
        #1;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passes++;
        checks++; if (done_o !== 1'b0 || div_zero_o !== 1'b0)
            $display("FAIL reset_done: got done=%b dz=%b want 0 0", done_o, div_zero_o); else passes++;
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0)
            $display("FAIL reset_hilo: got %h %h want 0 0", hi_o, lo_o); else passes++;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        int busy_c, done_e, done_c;
        logic dz, exp_dz;
        logic [31:0] hs, ls, h1;
        ops = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1};
        as  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000};
        bs  = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 6; i++) begin
            model_apply(ops[i], as[i], bs[i], exp_dz);
            // Vector 4 also fires a second start at E5, which must be ignored.
            run_op(ops[i], as[i], bs[i], 4, (i == 4), 1'b0, busy_c, done_e, done_c, dz, hs, ls, h1);
            checks++; if (busy_c !== 34) $display("FAIL dir%0d_busy: got %0d want 34", i, busy_c); else passes++;
            checks++; if (done_e !== 33) $display("FAIL dir%0d_done_edge: got %0d want 33", i, done_e); else passes++;
            checks++; if (done_c !== 1) $display("FAIL dir%0d_done_count: got %0d want 1", i, done_c); else passes++;
            checks++; if (hs !== model_hi || ls !== model_lo)
                $display("FAIL dir%0d_result: got %h_%h want %h_%h", i, hs, ls, model_hi, model_lo); else passes++;
            checks++; if (dz !== exp_dz) $display("FAIL dir%0d_dz: got %b want %b", i, dz, exp_dz); else passes++;
        end
        // Spot-check the model against literal expected results too.
        checks++; if (model_hi !== 32'h40000000 || model_lo !== 32'h00000000)
            $display("FAIL dir_last_literal: got %h_%h want 40000000_00000000", model_hi, model_lo); else passes++;
        repeat (4) begin
            @(posedge clk_i); #1;
            checks++; if (done_o !== 1'b0 || busy_o !== 1'b0)
                $display("FAIL no_second_op: got done=%b busy=%b want 0 0", done_o, busy_o); else passes++;
        end
    endtask

    task automatic test_div_zero;
        int busy_c, done_e, done_c;
        logic dz, exp_dz;
        logic [31:0] hs, ls, h1;
        hi_wr_i = 1'b1; wdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        hi_wr_i = 1'b0; lo_wr_i = 1'b1; wdata_i = 32'h9ABCDEF0;
        @(posedge clk_i); #1;
        lo_wr_i = 1'b0;
        checks++; if (hi_o !== 32'h12345678 || lo_o !== 32'h9ABCDEF0)
            $display("FAIL mthi_mtlo: got %h %h want 12345678 9abcdef0", hi_o, lo_o); else passes++;
        model_hi = 32'h12345678; model_lo = 32'h9ABCDEF0;
        model_apply(2'd3, 32'd100, 32'd0, exp_dz);
        // Also pokes hi/lo writes mid-operation; they must be ignored.
        run_op(2'd3, 32'd100, 32'd0, 10, 1'b0, 1'b1, busy_c, done_e, done_c, dz, hs, ls, h1);
        checks++; if (busy_c !== 34) $display("FAIL dz_busy: got %0d want 34", busy_c); else passes++;
        checks++; if (done_e !== 33) $display("FAIL dz_done_edge: got %0d want 33", done_e); else passes++;
        checks++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz); else passes++;
        checks++; if (hs !== 32'h12345678 || ls !== 32'h9ABCDEF0)
            $display("FAIL dz_keep: got %h %h want 12345678 9abcdef0", hs, ls); else passes++;
        checks++; if (div_zero_o !== 1'b0) $display("FAIL dz_pulse_end: got %b want 0", div_zero_o); else passes++;
    endtask

    task automatic test_random;
        int busy_c, done_e, done_c;
        logic dz, exp_dz;
        logic [31:0] hs, ls, h1, a, b;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3, 0));
            a  = ($urandom_range(7, 0) == 0) ? 32'h80000000 : $urandom;
            b  = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(3, 0) == 0) b = 32'($urandom_range(9, 1));
            model_apply(op, a, b, exp_dz);
            run_op(op, a, b, $urandom_range(33, 1), 1'($urandom), 1'($urandom),
                   busy_c, done_e, done_c, dz, hs, ls, h1);
            checks++; if (busy_c !== 34 || done_e !== 33 || done_c !== 1)
                $display("FAIL rnd%0d_timing: got busy=%0d done@%0d n=%0d want 34 33 1", i, busy_c, done_e, done_c);
            else passes++;
            checks++; if (hs !== model_hi || ls !== model_lo)
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h want %h_%h",
                         i, op, a, b, hs, ls, model_hi, model_lo); else passes++;
            checks++; if (dz !== exp_dz) $display("FAIL rnd%0d_dz: got %b want %b", i, dz, exp_dz); else passes++;
            checks++; if (hi_o !== model_hi || lo_o !== model_lo)
                $display("FAIL rnd%0d_hold: got %h_%h want %h_%h", i, hi_o, lo_o, model_hi, model_lo); else passes++;
        end
    endtask

    task automatic test_reset_abort;
        int busy_c, done_e, done_c;
        logic dz;
        logic [31:0] hs, ls, h1;
        bit saw_done;
        saw_done = 1'b0;
        op_i = 2'd0; op_a_i = 32'd3; op_b_i = 32'd4; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (done_o) saw_done = 1'b1;
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_o); else passes++;
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0)
            $display("FAIL abort_hilo: got %h %h want 0 0", hi_o, lo_o); else passes++;
        checks++; if (saw_done || done_o !== 1'b0)
            $display("FAIL abort_done: got %b want 0", saw_done | done_o); else passes++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_hi = 32'd0; model_lo = 32'd0;
        run_op(2'd0, 32'd3, 32'd4, 0, 1'b0, 1'b0, busy_c, done_e, done_c, dz, hs, ls, h1);
        checks++; if (busy_c !== 34 || done_e !== 33)
            $display("FAIL after_reset_timing: got busy=%0d done@%0d want 34 33", busy_c, done_e); else passes++;
        checks++; if (ls !== 32'd12 || hs !== 32'd0)
            $display("FAIL after_reset_result: got %h_%h want 0_c", hs, ls); else passes++;
    endtask

    task automatic test_start_priority;
        int busy_c, done_e, done_c;
        logic dz;
        logic [31:0] hs, ls, h1;
        hi_wr_i = 1'b1; wdata_i = 32'h11112222;
        @(posedge clk_i); #1;
        hi_wr_i = 1'b0;
        checks++; if (hi_o !== 32'h11112222) $display("FAIL prio_setup: got %h want 11112222", hi_o); else passes++;
        hi_wr_i = 1'b1; wdata_i = 32'hAAAA5555;
        run_op(2'd0, 32'd2, 32'd2, 0, 1'b0, 1'b0, busy_c, done_e, done_c, dz, hs, ls, h1);
        checks++; if (h1 !== 32'h11112222) $display("FAIL prio_drop: got %h want 11112222", h1); else passes++;
        checks++; if (hs !== 32'd0 || ls !== 32'd4)
            $display("FAIL prio_result: got %h_%h want 0_4", hs, ls); else passes++;
        checks++; if (busy_c !== 34) $display("FAIL prio_busy: got %0d want 34", busy_c); else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_reset_abort();
        test_start_priority();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
